pll_clken_gen: RTL

PLL_CLKEN_GEN -- requirements
Module: pll_clken_gen

---
 rtl/pll_clk_pkg.sv | 7 +
 rtl/pll_clken_gen_if.sv | 15 +
 rtl/pll_clken_ch.sv | 50 +++++
 rtl/pll_clken_gen.sv | 114 +++++++++++
 4 files changed

// File: rtl/pll_clk_pkg.sv
// pll_clk_pkg: shared FSM encoding and size limits for the PLL clock-enable generator
package pll_clk_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_LOCK, STABLE, RUN} state_t;
    localparam int MAX_NCH = 8;
    localparam int CH_W = $clog2(MAX_NCH);
    localparam int LOSS_W = 8;
endpackage

// File: rtl/pll_clken_gen_if.sv
// pll_clken_gen_if: configuration handshake bundle for the clock-enable generator
interface pll_clken_gen_if
    import pll_clk_pkg::*;
#(
    parameter int DIV_W = 16
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;
    logic             cfg_err;
    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready, cfg_err);
    modport slave (input cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready, cfg_err);
endinterface

// File: rtl/pll_clken_ch.sv
// pll_clken_ch: one clock-enable channel with divider counter, shadow config and aligned apply
module pll_clken_ch #(
    parameter int DIV_W = 16,
    parameter logic [DIV_W-1:0] DIV_RST = 4
) (
    input  logic             refclk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             run_nxt,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] phase,
    output logic             pending,
    output logic             ce
);
    logic [DIV_W-1:0] cnt, div_a, ph_a, sh_div, sh_ph, cnt_n, div_n, ph_n;
    logic wrap, apply;

    // next counter and active config; a shadow lands only at the wrap while running
    always_comb begin
        wrap = cnt == div_a - DIV_W'(1);
        apply = pending && (!run || wrap);
        div_n = apply ? sh_div : div_a;
        ph_n = apply ? sh_ph : ph_a;
        cnt_n = (run && run_nxt && !wrap) ? cnt + DIV_W'(1) : '0;
    end

    // channel registers; ce is registered from the next-cycle count
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            div_a <= DIV_RST;
            ph_a <= '0;
            sh_div <= DIV_RST;
            sh_ph <= '0;
            pending <= 1'b0;
            ce <= 1'b0;
        end else begin
            cnt <= cnt_n;
            div_a <= div_n;
            ph_a <= ph_n;
            ce <= run_nxt && (cnt_n == ph_n);
            pending <= load || (pending && !apply);
            if (load) begin
                sh_div <= div;
                sh_ph <= phase;
            end
        end
    end
endmodule

// File: rtl/pll_clken_gen.sv
// pll_clken_gen: lock-qualified multi-channel clock-enable generator in the PLL output domain
module pll_clken_gen
    import pll_clk_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DIV_W = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter logic [NCH*DIV_W-1:0] DIV_INIT = {16'd20, 16'd40, 16'd125, 16'd4}
) (
    input  logic              refclk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              extlock,
    input  logic              clr,
    pll_clken_gen_if.slave    cfg,
    output logic [NCH-1:0]    ce,
    output logic              locked,
    output logic              lost_lock,
    output logic [LOSS_W-1:0] loss_cnt
);
    localparam int LC_W = $clog2(LOCK_CYCLES) + 1;

    state_t state, nxt;
    logic s1, lock_s, loss, cfg_ok, accept;
    logic [LC_W-1:0] lcnt, lcnt_n;
    logic [NCH-1:0] pending;
    logic [MAX_NCH-1:0] pend_w;

    // two-flop synchroniser; the only place extlock is sampled
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) {lock_s, s1} <= 2'b00;
        else {lock_s, s1} <= {s1, extlock};
    end

    // state, stability counter and registered locked flag
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            lcnt <= '0;
            locked <= 1'b0;
        end else begin
            state <= nxt;
            lcnt <= lcnt_n;
            locked <= nxt == RUN;
        end
    end

    // lock qualification: lock_s must hold for LOCK_CYCLES consecutive cycles
    always_comb begin
        nxt = state;
        lcnt_n = '0;
        loss = 1'b0;
        if (!en) nxt = IDLE;
        else case (state)
            IDLE: nxt = WAIT_LOCK;
            WAIT_LOCK: nxt = lock_s ? STABLE : WAIT_LOCK;
            STABLE: begin
                if (!lock_s) nxt = WAIT_LOCK;
                else if (lcnt == LC_W'(LOCK_CYCLES - 1)) nxt = RUN;
                else lcnt_n = lcnt + LC_W'(1);
            end
            RUN: begin
                nxt = lock_s ? RUN : WAIT_LOCK;
                loss = !lock_s;
            end
            default: nxt = IDLE;
        endcase
    end

    // loss bookkeeping and reject pulse; a loss wins over a coincident clear
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            lost_lock <= 1'b0;
            loss_cnt <= '0;
            cfg.cfg_err <= 1'b0;
        end else begin
            if (loss) begin
                lost_lock <= 1'b1;
                loss_cnt <= clr ? LOSS_W'(1) : (loss_cnt == '1 ? loss_cnt : loss_cnt + LOSS_W'(1));
            end else if (clr) begin
                lost_lock <= 1'b0;
                loss_cnt <= '0;
            end
            cfg.cfg_err <= accept && !cfg_ok;
        end
    end

    // pad pending to the full channel-select range so out-of-range channels read as ready
    always_comb begin
        pend_w = '0;
        pend_w[NCH-1:0] = pending;
    end

    assign cfg.cfg_ready = ~pend_w[cfg.cfg_ch];
    assign accept = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_ok = (cfg.cfg_div != '0) && (cfg.cfg_phase < cfg.cfg_div) && (int'(cfg.cfg_ch) < NCH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pll_clken_ch #(
            .DIV_W(DIV_W),
            .DIV_RST(DIV_INIT[i*DIV_W +: DIV_W])
        ) u_ch (
            .refclk(refclk),
            .reset_n(reset_n),
            .run(state == RUN),
            .run_nxt(nxt == RUN),
            .load(accept && cfg_ok && cfg.cfg_ch == CH_W'(i)),
            .div(cfg.cfg_div),
            .phase(cfg.cfg_phase),
            .pending(pending[i]),
            .ce(ce[i])
        );
    end
endmodule
